// File: rtl/hex_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 7-segment display slice.
// Imported by the scan controller and its hexdriver.
package hex_disp_pkg;

    typedef enum logic {SCAN_BLANK, SCAN_DRIVE} scan_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] HEX_BLANK = 7'h7F;

    // Register width for a counter/index that ranges over n values; never below 1.
    function automatic int unsigned width_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_scan_ctrl_if.sv
// Display-word load channel: valid/ready handshake carrying one packed BCD word.
interface hex_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_data;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/hex_scan_ctrl_hexdriver.sv
// BCD digit to active-low 7-segment pattern (gfedcba); 0 and 10..15 render blank.
module hexdriver
    import hex_disp_pkg::*;
(
    input  bcd_digit_t  digit,
    output logic [6:0]  seg
);

    always_comb begin
        seg = HEX_BLANK;
        case (digit)
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = HEX_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Scans NUM_DIGITS BCD digits onto one shared decoder and a common-anode bank,
// with a blanking guard per slot and frame-aligned commit of loaded words.
module hex_scan_ctrl
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hex_scan_ctrl_if.slave        load,
    input  logic [NUM_DIGITS-1:0] digit_en,
    output logic [6:0]            HEX,
    output logic [NUM_DIGITS-1:0] AN_n,
    output logic                  frame_tick
);

    localparam int unsigned CW = width_for(SLOT_CYCLES);
    localparam int unsigned IW = width_for(NUM_DIGITS);

    localparam logic [CW-1:0] CNT_LAST       = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST       = IW'(NUM_DIGITS - 1);

    scan_state_t                    state_q, state_d;
    logic [CW-1:0]                  cnt_q;
    logic [IW-1:0]                  idx_q;
    bcd_digit_t [NUM_DIGITS-1:0]    disp_q;
    logic [4*NUM_DIGITS-1:0]        shadow_q;
    logic                           full_q;

    logic                           slot_wrap;
    logic                           frame_end;
    logic                           xfer;
    logic                           commit;
    logic [NUM_DIGITS-1:0]          an_d;
    bcd_digit_t                     scan_digit;
    logic [6:0]                     seg_dec;

    assign slot_wrap  = (cnt_q == CNT_LAST);
    assign frame_end  = slot_wrap && (idx_q == IDX_LAST);
    assign frame_tick = frame_end;

    assign load.load_ready = ~full_q;
    assign xfer   = load.load_valid && !full_q;
    assign commit = frame_end && full_q;

    // Slot timing: counter within the slot, index of the digit being scanned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (slot_wrap) begin
            cnt_q <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // State tracks the counter: BLANK for the first BLANK_CYCLES counts of each slot.
    always_comb begin
        state_d = state_q;
        an_d    = '1;
        case (state_q)
            SCAN_BLANK: begin
                if (cnt_q == CNT_BLANK_LAST) begin
                    state_d = SCAN_DRIVE;
                end
            end
            SCAN_DRIVE: begin
                an_d[idx_q] = ~digit_en[idx_q];
                if (slot_wrap) begin
                    state_d = SCAN_BLANK;
                end
            end
            default: state_d = SCAN_BLANK;
        endcase
    end

    // Shadow accepts one word at a time; it drains into the display only at frame end,
    // and a commit always takes the shadow contents from before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            full_q   <= 1'b0;
            disp_q   <= '0;
        end else begin
            if (commit) begin
                disp_q <= shadow_q;
            end
            if (xfer) begin
                shadow_q <= load.load_data;
            end
            full_q <= xfer || (full_q && !commit);
        end
    end

    // disp_q and idx_q only move on a slot wrap, so the decoder input settles as BLANK begins.
    assign scan_digit = disp_q[idx_q];

    hexdriver u_hexdriver (
        .digit (scan_digit),
        .seg   (seg_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            HEX  <= HEX_BLANK;
            AN_n <= '1;
        end else begin
            HEX  <= seg_dec;
            AN_n <= an_d;
        end
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Randomized and directed bench for hex_scan_ctrl against a cycle-count reference model.
module tb_hex_scan_ctrl;

    localparam int ND    = 4;
    localparam int SLOT  = 20;
    localparam int BLANK = 4;
    localparam int FRAME = ND * SLOT;

    logic        clk;
    logic        rst_n;
    logic [ND-1:0] digit_en;
    logic [6:0]  HEX;
    logic [ND-1:0] AN_n;
    logic        frame_tick;

    hex_scan_ctrl_if #(.NUM_DIGITS(ND)) load_if ();

    hex_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .SLOT_CYCLES  (SLOT),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_if.slave),
        .digit_en   (digit_en),
        .HEX        (HEX),
        .AN_n       (AN_n),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks;
    int unsigned failures;

    // Reference model: time since reset release, committed word, pending word.
    int unsigned t;
    logic [15:0] m_disp;
    logic [15:0] m_shadow;
    logic        m_full;
    logic [3:0]  m_an;
    logic [6:0]  m_hex;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%h want=%h", tag, t, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input int unsigned d);
        case (d)
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic model_reset();
        t        = 0;
        m_disp   = '0;
        m_shadow = '0;
        m_full   = 1'b0;
        m_an     = '1;
        m_hex    = 7'h7F;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model at the edge.
    task automatic run_cycle(input logic v, input logic [15:0] d, input logic [3:0] en);
        int unsigned slot;
        int unsigned phase;
        logic        tick;
        logic        rdy;
        logic [3:0]  nan;
        load_if.load_valid = v;
        load_if.load_data  = d;
        digit_en           = en;
        #1;
        check("an_n",       32'(AN_n),                 32'(m_an));
        check("hex",        32'(HEX),                  32'(m_hex));
        check("load_ready", 32'(load_if.load_ready),   32'(!m_full));
        check("frame_tick", 32'(frame_tick),           32'((t % FRAME) == FRAME - 1));
        @(posedge clk);
        slot  = (t / SLOT) % ND;
        phase = t % SLOT;
        nan   = '1;
        if (phase >= BLANK && en[slot]) nan[slot] = 1'b0;
        m_hex = ref_glyph(int'((m_disp >> (4 * slot)) & 16'hF));
        m_an  = nan;
        tick  = (t % FRAME) == FRAME - 1;
        rdy   = !m_full;
        if (tick && m_full) begin
            m_disp = m_shadow;
            m_full = 1'b0;
        end
        if (v && rdy) begin
            m_shadow = d;
            m_full   = 1'b1;
        end
        t++;
        @(negedge clk);
    endtask

    task automatic idle_until(input int unsigned frame_pos, input logic [3:0] en);
        for (int i = 0; i < FRAME && (t % FRAME) != frame_pos; i++) run_cycle(1'b0, 16'h0, en);
    endtask

    task automatic idle_cycles(input int unsigned n, input logic [3:0] en);
        for (int i = 0; i < int'(n); i++) run_cycle(1'b0, 16'h0, en);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        load_if.load_valid = 1'b0;
        load_if.load_data  = '0;
        digit_en = '0;
        model_reset();

        // Reset held for five cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_an_n",  32'(AN_n),               32'hF);
            check("rst_hex",   32'(HEX),                32'h7F);
            check("rst_ready", 32'(load_if.load_ready), 32'h1);
            check("rst_tick",  32'(frame_tick),         32'h0);
        end
        rst_n = 1'b1;
        model_reset();

        // Basic scan of 4321
        run_cycle(1'b1, 16'h4321, 4'hF);
        idle_cycles(2 * FRAME + 5, 4'hF);

        // Mid-frame load of 9999
        idle_until(30, 4'hF);
        run_cycle(1'b1, 16'h9999, 4'hF);
        idle_cycles(FRAME + 10, 4'hF);

        // Collision: pending word, new word offered on the frame_tick cycle and held
        idle_until(10, 4'hF);
        run_cycle(1'b1, 16'h5678, 4'hF);
        idle_until(FRAME - 1, 4'hF);
        run_cycle(1'b1, 16'h1357, 4'hF);
        run_cycle(1'b1, 16'h1357, 4'hF);
        idle_cycles(2 * FRAME, 4'hF);

        // Enable mask and blank codes
        run_cycle(1'b1, 16'h0A05, 4'b1010);
        idle_cycles(2 * FRAME + 3, 4'b1010);

        // Random traffic
        begin
            logic [3:0] en;
            en = 4'hF;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 39) == 0) en = 4'($urandom);
                run_cycle($urandom_range(0, 15) == 0, 16'($urandom), en);
            end
        end

        // Async reset mid-DRIVE with a word pending
        idle_until(2, 4'hF);
        run_cycle(1'b1, 16'h8765, 4'hF);
        idle_until(30, 4'hF);
        check("pre_rst_an_low", 32'(AN_n != 4'hF), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_an_n",  32'(AN_n),               32'hF);
        check("async_hex",   32'(HEX),                32'h7F);
        check("async_ready", 32'(load_if.load_ready), 32'h1);
        for (int i = 0; i < 3; i++) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle_cycles(3 * FRAME, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
